// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked execute-stage ALU; MUL/DIV/MOD iterate over WIDTH cycles.
// Build option: define ALU_FAST_MUL_EN to make MUL a single-cycle combinational multiply.
module alu_multicycle #(
    parameter int WIDTH      = 32,
    parameter bit SIGNED_CMP = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [WIDTH-1:0] immx,
    input  logic             is_immediate,
    input  logic [12:0]      alu_signals,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             flags_e,
    output logic             flags_gt,
    output logic             op_err
);
    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, next_state;

    logic [WIDTH-1:0] b, single_res, asr_val, acc, quo, mcand, divisor, acc_n, quo_n;
    logic [WIDTH:0]   shifted, trial;
    logic [SW-1:0]    cnt;
    logic             accept, one_hot, iter_op, shift_big, is_mul, is_mod, cmp_gt;

    assign b         = is_immediate ? immx : op2;
    assign one_hot   = $onehot(alu_signals);
    assign shift_big = |(b >> SW);
    assign asr_val   = $signed(op1) >>> b[SW-1:0];
    assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = state == DONE;
    assign cmp_gt    = SIGNED_CMP ? ($signed(op1) > $signed(b)) : (op1 > b);
`ifdef ALU_FAST_MUL_EN
    assign iter_op   = one_hot & (alu_signals[4] | alu_signals[5]);
`else
    assign iter_op   = one_hot & (|alu_signals[5:3]);
`endif

    // Result of every op finishing in its accept cycle; illegal encodings give zero
    always_comb begin
        single_res = '0;
        case (alu_signals)
            13'h0001:           single_res = op1 + b;
            13'h0002, 13'h0004: single_res = op1 - b;
`ifdef ALU_FAST_MUL_EN
            13'h0008:           single_res = op1 * b;
`endif
            13'h0040:           single_res = shift_big ? '0 : op1 << b[SW-1:0];
            13'h0080:           single_res = shift_big ? '0 : op1 >> b[SW-1:0];
            13'h0100:           single_res = shift_big ? {WIDTH{op1[WIDTH-1]}} : asr_val;
            13'h0200:           single_res = op1 | b;
            13'h0400:           single_res = op1 & b;
            13'h0800:           single_res = ~op1;
            13'h1000:           single_res = b;
            default:            single_res = '0;
        endcase
    end

    // One shift-add multiply step or one restoring-division step (quo holds dividend bits)
    always_comb begin
        shifted = {acc, quo[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
        acc_n   = is_mul ? acc + (quo[0] ? mcand : '0)
                         : (trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0]);
        quo_n   = is_mul ? quo >> 1 : {quo[WIDTH-2:0], ~trial[WIDTH]};
    end

    // Handshake FSM next state: accept from IDLE or a draining DONE, iterate in BUSY
    always_comb begin
        next_state = state;
        case (state)
            BUSY:    next_state = (cnt == LAST) ? DONE : BUSY;
            DONE:    next_state = accept ? (iter_op ? BUSY : DONE) : (out_ready ? IDLE : DONE);
            default: next_state = accept ? (iter_op ? BUSY : DONE) : IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Operand capture, iteration registers, result and flag registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_result <= '0;
            flags_e    <= 1'b0;
            flags_gt   <= 1'b0;
            op_err     <= 1'b0;
            acc        <= '0;
            quo        <= '0;
            mcand      <= '0;
            divisor    <= '0;
            cnt        <= '0;
            is_mul     <= 1'b0;
            is_mod     <= 1'b0;
        end else if (accept) begin
            acc     <= '0;
            quo     <= alu_signals[3] ? b : op1;
            mcand   <= op1;
            divisor <= b;
            cnt     <= '0;
            is_mul  <= alu_signals[3];
            is_mod  <= alu_signals[5];
            if (!iter_op) begin
                alu_result <= single_res;
                op_err     <= ~one_hot;
            end
            if (alu_signals == 13'h0004) begin
                flags_e  <= op1 == b;
                flags_gt <= cmp_gt;
            end
        end else if (state == BUSY) begin
            acc   <= acc_n;
            quo   <= quo_n;
            mcand <= mcand << 1;
            cnt   <= cnt + 1'b1;
            if (cnt == LAST) begin
                alu_result <= (is_mul | is_mod) ? acc_n : quo_n;
                op_err     <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: randomized self-checking bench for alu_multicycle (signed and unsigned CMP instances)
module tb_alu_multicycle;
    localparam int W = 32;
`ifdef ALU_FAST_MUL_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = W;
`endif
    localparam logic [12:0] ADD = 13'h0001, SUB = 13'h0002, CMP = 13'h0004, MUL = 13'h0008;
    localparam logic [12:0] DIV = 13'h0010, MOD = 13'h0020, LSL = 13'h0040, LSR = 13'h0080;
    localparam logic [12:0] ASR = 13'h0100, OP_OR = 13'h0200, OP_AND = 13'h0400;
    localparam logic [12:0] OP_NOT = 13'h0800, MOV = 13'h1000;

    logic         clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, is_immediate = 1'b0, out_ready = 1'b1;
    logic [W-1:0] op1 = '0, op2 = '0, immx = '0;
    logic [12:0]  alu_signals = '0;
    logic         in_ready, out_valid, flags_e, flags_gt, op_err;
    logic         in_ready_u, out_valid_u, flags_e_u, flags_gt_u, op_err_u;
    logic [W-1:0] alu_result, alu_result_u;
    logic         exp_e = 1'b0, exp_gt = 1'b0, exp_ugt = 1'b0;
    int           n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(W), .SIGNED_CMP(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .immx(immx), .is_immediate(is_immediate), .alu_signals(alu_signals),
        .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
        .flags_e(flags_e), .flags_gt(flags_gt), .op_err(op_err));

    alu_multicycle #(.WIDTH(W), .SIGNED_CMP(1'b0)) dut_u (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_u),
        .op1(op1), .op2(op2), .immx(immx), .is_immediate(is_immediate), .alu_signals(alu_signals),
        .out_valid(out_valid_u), .out_ready(out_ready), .alu_result(alu_result_u),
        .flags_e(flags_e_u), .flags_gt(flags_gt_u), .op_err(op_err_u));

    // Behavioural reference: what each opcode means arithmetically
    function automatic logic [W-1:0] model(input logic [12:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W-1:0] sa, r;
        sa = a;
        if ($countones(s) != 1) return '0;
        case (s)
            ADD:      return a + b;
            SUB, CMP: return a - b;
            MUL:      return a * b;
            DIV:      return (b == 0) ? '1 : a / b;
            MOD:      return (b == 0) ? a : a % b;
            LSL:      return (b >= W) ? '0 : a << b;
            LSR:      return (b >= W) ? '0 : a >> b;
            ASR: begin
                if (b >= W) return {W{a[W-1]}};
                r = sa >>> b;
                return r;
            end
            OP_OR:    return a | b;
            OP_AND:   return a & b;
            OP_NOT:   return ~a;
            default:  return b;
        endcase
    endfunction

    function automatic int lat_of(input logic [12:0] s);
        if (s == DIV || s == MOD) return W;
        if (s == MUL) return MUL_LAT;
        return 0;
    endfunction

    task automatic upd_flags(input logic [12:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        if (s == CMP) begin
            exp_e   = a == b;
            exp_gt  = $signed(a) > $signed(b);
            exp_ugt = a > b;
        end
    endtask

    // Offer one op, scramble inputs after accept, count edges after accept until out_valid
    task automatic exec(input logic [12:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit imm, output int lat, output bit rb);
        @(negedge clk);
        alu_signals = s; op1 = a; is_immediate = imm; out_ready = 1'b1; in_valid = 1'b1;
        op2  = imm ? $urandom : b;
        immx = imm ? b : $urandom;
        @(posedge clk); #1;
        in_valid = 1'b0; op1 = $urandom; op2 = $urandom; immx = $urandom;
        alu_signals = 13'($urandom); is_immediate = ~imm;
        lat = 0; rb = 1'b0;
        while (!out_valid && lat < 100) begin
            rb |= in_ready;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, out_valid, alu_result, flags_e, flags_gt, op_err} !== {1'b1, 1'b0, 32'h0, 3'b000}) begin
            n_bad++;
            $display("FAIL reset: rdy=%b vld=%b res=%h e=%b gt=%b err=%b want rdy=1 vld=0 res=0 e=0 gt=0 err=0",
                     in_ready, out_valid, alu_result, flags_e, flags_gt, op_err);
        end
        n_cmp++;
        if ({in_ready_u, out_valid_u} !== 2'b10) begin
            n_bad++; $display("FAIL reset_u: rdy=%b vld=%b want 1 0", in_ready_u, out_valid_u);
        end
        @(negedge clk); reset_n = 1'b1;
    endtask

    task automatic test_cmp();
        int lat; bit rb;
        exec(CMP, 32'hFFFF_FFFF, 32'd1, 1'b0, lat, rb);
        upd_flags(CMP, 32'hFFFF_FFFF, 32'd1);
        n_cmp++;
        if ({flags_e, flags_gt} !== 2'b00) begin
            n_bad++; $display("FAIL cmp_signed: e=%b gt=%b want 0 0", flags_e, flags_gt);
        end
        n_cmp++;
        if ({flags_e_u, flags_gt_u} !== 2'b01) begin
            n_bad++; $display("FAIL cmp_unsigned: e=%b gt=%b want 0 1", flags_e_u, flags_gt_u);
        end
        n_cmp++;
        if (alu_result !== 32'hFFFF_FFFE || lat !== 0) begin
            n_bad++; $display("FAIL cmp_result: res=%h lat=%0d want fffffffe lat 0", alu_result, lat);
        end
        exec(CMP, 32'd42, 32'd42, 1'b1, lat, rb);
        upd_flags(CMP, 32'd42, 32'd42);
        n_cmp++;
        if ({flags_e, flags_gt, flags_gt_u} !== 3'b100) begin
            n_bad++; $display("FAIL cmp_equal: e=%b gt=%b ugt=%b want 1 0 0", flags_e, flags_gt, flags_gt_u);
        end
    endtask

    task automatic test_add();
        int lat; bit rb;
        exec(ADD, 32'd5, 32'd7, 1'b1, lat, rb);
        n_cmp++;
        if (alu_result !== 32'd12 || lat !== 0 || op_err !== 1'b0) begin
            n_bad++; $display("FAIL add: res=%0d lat=%0d err=%b want 12 lat 0 err 0", alu_result, lat, op_err);
        end
        n_cmp++;
        if ({flags_e, flags_gt} !== {exp_e, exp_gt}) begin
            n_bad++; $display("FAIL add_flags: e=%b gt=%b want %b %b", flags_e, flags_gt, exp_e, exp_gt);
        end
    endtask

    task automatic test_div();
        logic [12:0] s [4] = '{DIV, MOD, DIV, MOD};
        logic [W-1:0] a [4] = '{100, 100, 9, 9};
        logic [W-1:0] b [4] = '{7, 7, 0, 0};
        logic [W-1:0] want [4] = '{14, 2, 32'hFFFF_FFFF, 9};
        int lat; bit rb;
        for (int i = 0; i < 4; i++) begin
            exec(s[i], a[i], b[i], 1'b0, lat, rb);
            n_cmp++;
            if (alu_result !== want[i] || lat !== W || rb !== 1'b0 || op_err !== 1'b0) begin
                n_bad++;
                $display("FAIL divmod_%0d: res=%h lat=%0d rdy_busy=%b err=%b want %h lat %0d rdy_busy 0 err 0",
                         i, alu_result, lat, rb, op_err, want[i], W);
            end
        end
    endtask

    task automatic test_mul();
        int lat; bit rb;
        exec(MUL, 32'h1_0000, 32'h1_0000, 1'b0, lat, rb);
        n_cmp++;
        if (alu_result !== 32'h0 || lat !== MUL_LAT) begin
            n_bad++; $display("FAIL mul_wrap: res=%h lat=%0d want 0 lat %0d", alu_result, lat, MUL_LAT);
        end
        exec(MUL, 32'd123457, 32'd7890, 1'b1, lat, rb);
        n_cmp++;
        if (alu_result !== 32'd974075730) begin
            n_bad++; $display("FAIL mul_small: res=%0d want 974075730", alu_result);
        end
    endtask

    task automatic test_shift();
        logic [12:0] s [3] = '{ASR, LSR, LSL};
        logic [W-1:0] a [3] = '{32'h8000_0000, 32'h8000_0000, 1};
        logic [W-1:0] b [3] = '{40, 40, 31};
        logic [W-1:0] want [3] = '{32'hFFFF_FFFF, 0, 32'h8000_0000};
        int lat; bit rb;
        for (int i = 0; i < 3; i++) begin
            exec(s[i], a[i], b[i], i[0], lat, rb);
            n_cmp++;
            if (alu_result !== want[i] || lat !== 0) begin
                n_bad++; $display("FAIL shift_%0d: res=%h lat=%0d want %h lat 0", i, alu_result, lat, want[i]);
            end
        end
    endtask

    task automatic test_op_err();
        logic [12:0] s [2] = '{13'h0003, 13'h0000};
        int lat; bit rb;
        for (int i = 0; i < 2; i++) begin
            exec(s[i], 32'd5, 32'd7, 1'b0, lat, rb);
            n_cmp++;
            if (op_err !== 1'b1 || alu_result !== 32'h0 || lat !== 0 || {flags_e, flags_gt} !== {exp_e, exp_gt}) begin
                n_bad++;
                $display("FAIL op_err_%0d: err=%b res=%h lat=%0d e=%b gt=%b want err 1 res 0 lat 0 e=%b gt=%b",
                         i, op_err, alu_result, lat, flags_e, flags_gt, exp_e, exp_gt);
            end
        end
        exec(OP_OR, 32'h0F0, 32'h00F, 1'b1, lat, rb);
        n_cmp++;
        if (op_err !== 1'b0 || alu_result !== 32'h0FF) begin
            n_bad++; $display("FAIL op_err_clear: err=%b res=%h want 0 0ff", op_err, alu_result);
        end
    endtask

    task automatic test_stall();
        int n;
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        alu_signals = MUL; op1 = 3; op2 = 5; is_immediate = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; op1 = $urandom; op2 = $urandom;
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        n_cmp++;
        if (n !== MUL_LAT || alu_result !== 32'd15) begin
            n_bad++; $display("FAIL stall_first: res=%0d lat=%0d want 15 lat %0d", alu_result, n, MUL_LAT);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || alu_result !== 32'd15 || in_ready !== 1'b0) begin
                n_bad++; $display("FAIL stall_hold_%0d: vld=%b res=%0d rdy=%b want 1 15 0", i, out_valid, alu_result, in_ready);
            end
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL stall_drain: vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge clk);
        alu_signals = DIV; op1 = 100; op2 = 7; is_immediate = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL busy_before_reset: vld=%b rdy=%b want 0 0", out_valid, in_ready);
        end
        #1; reset_n = 1'b0; #1;
        exp_e = 1'b0; exp_gt = 1'b0; exp_ugt = 1'b0;
        n_cmp++;
        if ({out_valid, in_ready, alu_result, flags_e, flags_gt, op_err} !== {1'b0, 1'b1, 32'h0, 3'b000}) begin
            n_bad++;
            $display("FAIL async_reset: vld=%b rdy=%b res=%h e=%b gt=%b err=%b want 0 1 0 0 0 0",
                     out_valid, in_ready, alu_result, flags_e, flags_gt, op_err);
        end
        @(negedge clk); reset_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; seen |= out_valid; end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++; $display("FAIL reset_discard: out_valid seen=%b want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] s; logic [W-1:0] a, b, want; int k;
        for (int i = 0; i < 20; i++) begin
            k = $urandom_range(0, 9);
            s = 13'h1 << ((k < 3) ? k : k + 3);
            a = $urandom;
            b = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 40) : $urandom;
            @(negedge clk);
            alu_signals = s; op1 = a; op2 = b; is_immediate = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
            @(posedge clk); #1;
            want = model(s, a, b);
            upd_flags(s, a, b);
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || alu_result !== want || {flags_e, flags_gt} !== {exp_e, exp_gt}) begin
                n_bad++;
                $display("FAIL b2b_%0d op=%h: vld=%b rdy=%b res=%h e=%b gt=%b want 1 1 %h %b %b",
                         i, s, out_valid, in_ready, alu_result, flags_e, flags_gt, want, exp_e, exp_gt);
            end
        end
        @(negedge clk); in_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [12:0] s; logic [W-1:0] a, b, want; int k, lat; bit rb, imm, bad;
        for (int i = 0; i < 80; i++) begin
            k = $urandom_range(0, 14);
            s = (k < 13) ? 13'h1 << k : (k == 13) ? 13'h0 : 13'h0003 << $urandom_range(0, 11);
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom;
            if (s == CMP && $urandom_range(0, 2) == 0) b = a;
            imm = 1'($urandom_range(0, 1));
            exec(s, a, b, imm, lat, rb);
            want = model(s, a, b);
            bad = ($countones(s) != 1);
            upd_flags(s, a, b);
            n_cmp++;
            if (alu_result !== want || alu_result_u !== want || op_err !== bad || op_err_u !== bad || out_valid_u !== 1'b1) begin
                n_bad++;
                $display("FAIL rand_res_%0d op=%h a=%h b=%h: res=%h res_u=%h err=%b vld_u=%b want %h err %b",
                         i, s, a, b, alu_result, alu_result_u, op_err, out_valid_u, want, bad);
            end
            n_cmp++;
            if ({flags_e, flags_gt, flags_e_u, flags_gt_u} !== {exp_e, exp_gt, exp_e, exp_ugt}) begin
                n_bad++;
                $display("FAIL rand_flags_%0d op=%h: e=%b gt=%b e_u=%b gt_u=%b want %b %b %b %b",
                         i, s, flags_e, flags_gt, flags_e_u, flags_gt_u, exp_e, exp_gt, exp_e, exp_ugt);
            end
            n_cmp++;
            if (lat !== (bad ? 0 : lat_of(s)) || rb !== 1'b0) begin
                n_bad++;
                $display("FAIL rand_lat_%0d op=%h: lat=%0d rdy_busy=%b want lat %0d rdy_busy 0",
                         i, s, lat, rb, bad ? 0 : lat_of(s));
            end
        end
    endtask

    initial begin
        test_reset();
        test_cmp();
        test_add();
        test_div();
        test_mul();
        test_shift();
        test_op_err();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
